fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry
// hold buffer to decode, redirect with in-flight response kill.
// Ports: clk, res (sync active-high), redirect/redirectPc from execute,
//   imemReq/imemAddr/imemAck/imemData to instruction memory,
//   instValid/instReady/instOut/instPc to decode, pcOut, instCount.
module fetch_ctrl #(
  parameter int          DBITS    = 32,
  parameter logic [31:0] START_PC = 32'h40
) (
  input  logic             clk,
  input  logic             res,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirectPc,
  output logic             imemReq,
  output logic [DBITS-1:0] imemAddr,
  input  logic             imemAck,
  input  logic [31:0]      imemData,
  output logic             instValid,
  input  logic             instReady,
  output logic [31:0]      instOut,
  output logic [DBITS-1:0] instPc,
  output logic [DBITS-1:0] pcOut,
  output logic [31:0]      instCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic             kill_q, kill_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      inst_q, inst_d;
  logic [DBITS-1:0] ipc_q, ipc_d;
  logic [DBITS-1:0] redir_pc;

  // Word-align the target; masking keeps every input bit in use.
  assign redir_pc = redirectPc & ~DBITS'(3);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      pc_q    <= DBITS'(START_PC);
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redir_pc;
      end
      REQ: begin
        // Request at the old PC has gone out; its reply must be dropped.
        state_d = WAIT;
        if (redirect) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (imemAck) begin
          if (redirect) begin
            pc_d    = redir_pc;
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = imemData;
            ipc_d   = pc_q;
            pc_d    = pc_q + DBITS'(4);
            state_d = HOLD;
          end
        end else if (redirect) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (instReady) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imemReq   = (state_q == REQ);
    imemAddr  = pc_q;
    instValid = (state_q == HOLD) && !redirect;
    instOut   = inst_q;
    instPc    = ipc_q;
    pcOut     = pc_q;
    instCount = cnt_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instValid;
  logic        instReady;
  logic [31:0] instOut;
  logic [31:0] instPc;
  logic [31:0] pcOut;
  logic [31:0] instCount;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .res(res),
    .redirect(redirect), .redirectPc(redirectPc),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData),
    .instValid(instValid), .instReady(instReady),
    .instOut(instOut), .instPc(instPc),
    .pcOut(pcOut), .instCount(instCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    res = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1; redirect = 1'b1; redirectPc = 32'h500;
    imemAck = 1'b1; imemData = 32'h1; instReady = 1'b1;
    step();
    step();
    redirect = 1'b0; imemAck = 1'b0; instReady = 1'b0;
    #1;
    checks++; if (pcOut !== 32'h40) begin fails++;
      $display("FAIL rst_pc got %h exp %h", pcOut, 32'h40); end
    checks++; if (instValid !== 1'b0) begin fails++;
      $display("FAIL rst_valid got %b exp 0", instValid); end
    checks++; if (imemReq !== 1'b0) begin fails++;
      $display("FAIL rst_req got %b exp 0", imemReq); end
    checks++; if (instCount !== 32'h0) begin fails++;
      $display("FAIL rst_cnt got %h exp 0", instCount); end
    checks++; if (instOut !== 32'h0 || instPc !== 32'h0) begin fails++;
      $display("FAIL rst_inst got %h/%h exp 0/0", instOut, instPc); end
    res = 1'b0;
    // Stray ack in IDLE must be ignored.
    imemAck = 1'b1;
    step();
    imemAck = 1'b0;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin fails++;
      $display("FAIL rst_first_req got %b/%h exp 1/40", imemReq, imemAddr);
    end
    checks++; if (instValid !== 1'b0) begin fails++;
      $display("FAIL rst_idle_ack got %b exp 0", instValid); end
  endtask

  task automatic test_basic();
    logic [31:0] a;
    do_reset();
    instReady = 1'b1;
    for (int n = 0; n < 3; n++) begin
      a = 32'h40 + 32'(4 * n);
      step();
      checks++; if (imemReq !== 1'b1 || imemAddr !== a) begin fails++;
        $display("FAIL basic_req%0d got %b/%h exp 1/%h",
                 n, imemReq, imemAddr, a); end
      step();
      checks++; if (imemReq !== 1'b0) begin fails++;
        $display("FAIL basic_wait%0d got %b exp 0", n, imemReq); end
      imemAck = 1'b1; imemData = 32'hA0 + 32'(n);
      step();
      imemAck = 1'b0;
      checks++;
      if (instValid !== 1'b1 || instOut !== 32'hA0 + 32'(n) ||
          instPc !== a || pcOut !== a + 32'd4) begin
        fails++;
        $display("FAIL basic_hold%0d got %b/%h/%h/%h exp 1/%h/%h/%h",
                 n, instValid, instOut, instPc, pcOut,
                 32'hA0 + 32'(n), a, a + 32'd4);
      end
    end
    step();
    checks++; if (instCount !== 32'd3) begin fails++;
      $display("FAIL basic_cnt got %0d exp 3", instCount); end
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h4C) begin fails++;
      $display("FAIL basic_next got %b/%h exp 1/4c", imemReq, imemAddr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instReady = 1'b0;
    step();
    step();
    imemAck = 1'b1; imemData = 32'h12345678;
    step();
    imemAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instValid !== 1'b1 || instOut !== 32'h12345678 ||
          instPc !== 32'h40 || imemReq !== 1'b0 || instCount !== 0) begin
        fails++;
        $display("FAIL bp_stall%0d got %b/%h/%h/%b/%0d exp 1/12345678/40/0/0",
                 i, instValid, instOut, instPc, imemReq, instCount);
      end
      step();
    end
    instReady = 1'b1;
    step();
    instReady = 1'b0;
    checks++;
    if (instCount !== 32'd1 || imemReq !== 1'b1 || imemAddr !== 32'h44) begin
      fails++;
      $display("FAIL bp_release got %0d/%b/%h exp 1/1/44",
               instCount, imemReq, imemAddr);
    end
    step();
    checks++; if (instCount !== 32'd1) begin fails++;
      $display("FAIL bp_single got %0d exp 1", instCount); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    instReady = 1'b1;
    step();
    step();
    redirect = 1'b1; redirectPc = 32'h1003;
    step();
    redirect = 1'b0;
    checks++; if (pcOut !== 32'h1000 || imemReq !== 1'b0) begin fails++;
      $display("FAIL rw_pc got %h/%b exp 1000/0", pcOut, imemReq); end
    step();
    imemAck = 1'b1; imemData = 32'hDEAD;
    step();
    imemAck = 1'b0;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h1000 || instValid !== 1'b0) begin
      fails++;
      $display("FAIL rw_drop got %b/%h/%b exp 1/1000/0",
               imemReq, imemAddr, instValid);
    end
    step();
    imemAck = 1'b1; imemData = 32'hBEEF;
    step();
    imemAck = 1'b0;
    checks++;
    if (instValid !== 1'b1 || instPc !== 32'h1000 || instOut !== 32'hBEEF)
    begin
      fails++;
      $display("FAIL rw_deliver got %b/%h/%h exp 1/1000/beef",
               instValid, instPc, instOut);
    end
    step();
    checks++; if (instCount !== 32'd1 || imemAddr !== 32'h1004) begin
      fails++;
      $display("FAIL rw_after got %0d/%h exp 1/1004", instCount, imemAddr);
    end
  endtask

  task automatic test_redirect_req();
    do_reset();
    instReady = 1'b1;
    step();
    redirect = 1'b1; redirectPc = 32'h300;
    #1;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin fails++;
      $display("FAIL rr_old got %b/%h exp 1/40", imemReq, imemAddr); end
    step();
    redirect = 1'b0;
    imemAck = 1'b1; imemData = 32'h55;
    step();
    imemAck = 1'b0;
    checks++;
    if (instCount !== 0 || imemReq !== 1'b1 || imemAddr !== 32'h300 ||
        instValid !== 1'b0) begin
      fails++;
      $display("FAIL rr_kill got %0d/%b/%h/%b exp 0/1/300/0",
               instCount, imemReq, imemAddr, instValid);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    instReady = 1'b1;
    step();
    step();
    imemAck = 1'b1; imemData = 32'h11;
    step();
    imemAck = 1'b0;
    redirect = 1'b1; redirectPc = 32'h200;
    #1;
    checks++; if (instValid !== 1'b0) begin fails++;
      $display("FAIL rh_valid got %b exp 0", instValid); end
    step();
    redirect = 1'b0;
    checks++;
    if (instCount !== 0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin
      fails++;
      $display("FAIL rh_next got %0d/%b/%h exp 0/1/200",
               instCount, imemReq, imemAddr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    instReady = 1'b1;
    redirect = 1'b1; redirectPc = 32'hFFFFFFFC;
    step();
    redirect = 1'b0;
    checks++; if (imemAddr !== 32'hFFFFFFFC) begin fails++;
      $display("FAIL wrap_req got %h exp fffffffc", imemAddr); end
    step();
    imemAck = 1'b1; imemData = 32'h77;
    step();
    imemAck = 1'b0;
    checks++; if (pcOut !== 32'h0 || instPc !== 32'hFFFFFFFC) begin
      fails++;
      $display("FAIL wrap_pc got %h/%h exp 0/fffffffc", pcOut, instPc);
    end
    step();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin fails++;
      $display("FAIL wrap_next got %b/%h exp 1/0", imemReq, imemAddr); end
  endtask

  task automatic test_reset_in_wait();
    instReady = 1'b1;
    step();
    res = 1'b1; imemAck = 1'b1; imemData = 32'h99;
    step();
    res = 1'b0; imemAck = 1'b0;
    checks++;
    if (pcOut !== 32'h40 || instValid !== 1'b0 || instCount !== 0 ||
        imemReq !== 1'b0 || instOut !== 32'h0) begin
      fails++;
      $display("FAIL rw_rst got %h/%b/%0d/%b/%h exp 40/0/0/0/0",
               pcOut, instValid, instCount, imemReq, instOut);
    end
    step();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin fails++;
      $display("FAIL rw_rst_req got %b/%h exp 1/40", imemReq, imemAddr); end
  endtask

  initial begin
    res = 1'b1; redirect = 1'b0; redirectPc = '0;
    imemAck = 1'b0; imemData = '0; instReady = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_hold();
    test_wrap();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
